// File: rtl/run_controller_pkg.sv
// Shared state encoding and clock-enable rule for the run/step/halt sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package run_controller_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam int RESET_CYCLES_DEF    = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int COUNT_WIDTH_DEF     = 32;

  // HALT is combinational from the processor, so it must gate the enable in the same cycle.
  function automatic logic clk_en_f(input state_t st, input logic halt);
    return (st == ST_RESET) || (((st == ST_RUN) || (st == ST_STEP)) && !halt);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-sample debouncer, rising-edge pulse.
// Latency: 2 sync + DEBOUNCE_CYCLES + 1 edge cycles from raw rise to pulse.
// Backpressure: none; pulse is a single-cycle strobe.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          level_d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      level_d_q <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      // Any sample agreeing with the current level restarts the stability window.
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      level_d_q <= level_q;
      pulse     <= level_q & ~level_d_q;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run/step/halt sequencer driving processor reset, clock enable and executed-cycle counter.
// Latency: RUN_REQ/RESET_REQ 3 cycles to effect; STEP_REQ 2+DEBOUNCE_CYCLES+2 cycles.
// Backpressure: none; HALT combinationally drops CPU_CLK_EN in the cycle it rises.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int RESET_CYCLES    = RESET_CYCLES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int COUNT_WIDTH     = COUNT_WIDTH_DEF
) (
  input  logic                   CLK,
  input  logic                   RST_bar,
  input  logic                   HALT,
  input  logic                   RUN_REQ,
  input  logic                   STEP_REQ,
  input  logic                   RESET_REQ,
  output logic                   CPU_CLK_EN,
  output logic                   CPU_RST_bar,
  output logic                   RUNNING,
  output logic                   HALTED,
  output logic [COUNT_WIDTH-1:0] CYCLE_COUNT
);

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LOAD = RCW'(RESET_CYCLES - 1);

  logic [1:0]             run_sync_q;
  logic [2:0]             rreq_q;
  logic                   run_sync;
  logic                   reset_pulse;
  logic                   step_pulse;
  state_t                 state_q;
  state_t                 state_d;
  logic [RCW-1:0]         rst_cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic                   count_en;

  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      run_sync_q <= '0;
      rreq_q     <= '0;
    end else begin
      run_sync_q <= {run_sync_q[0], RUN_REQ};
      rreq_q     <= {rreq_q[1:0], RESET_REQ};
    end
  end

  assign run_sync    = run_sync_q[1];
  assign reset_pulse = rreq_q[1] & ~rreq_q[2];

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clk  (CLK),
    .rst_n(RST_bar),
    .raw  (STEP_REQ),
    .pulse(step_pulse)
  );

  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    CPU_CLK_EN  = clk_en_f(state_q, HALT);
    CPU_RST_bar = (state_q != ST_RESET);
    RUNNING     = (state_q == ST_RUN);
    HALTED      = (state_q == ST_HALTED);
    count_en    = CPU_CLK_EN && (state_q != ST_RESET);
    case (state_q)
      ST_RESET:  if (rst_cnt_q == '0) state_d = ST_IDLE;
      ST_IDLE: begin
        // RUN takes precedence; a coincident step is dropped.
        if (run_sync)        state_d = ST_RUN;
        else if (step_pulse) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (HALT)           state_d = ST_HALTED;
        else if (!run_sync) state_d = ST_IDLE;
      end
      ST_STEP:   state_d = HALT ? ST_HALTED : ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RESET;
    endcase
    if (reset_pulse) state_d = ST_RESET;
  end

  always_ff @(posedge CLK) begin
    if (!RST_bar || reset_pulse) begin
      rst_cnt_q <= RST_LOAD;
      cnt_q     <= '0;
    end else begin
      if ((state_q == ST_RESET) && (rst_cnt_q != '0)) rst_cnt_q <= rst_cnt_q - 1'b1;
      if (count_en && (cnt_q != '1))                  cnt_q     <= cnt_q + 1'b1;
    end
  end

  assign CYCLE_COUNT = cnt_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: scripted scenarios with literal expectations plus randomized
// stimulus, all checked every cycle against a behavioural model of the sequencer.
module tb_run_controller;

  localparam int RC = 4;
  localparam int DC = 16;

  logic        clk = 1'b0;
  logic        RST_bar, HALT, RUN_REQ, STEP_REQ, RESET_REQ;
  logic        en, rstb, running, halted;
  logic [31:0] cnt;
  logic        en4, rstb4, running4, halted4;
  logic [3:0]  cnt4;

  int vectors = 0;
  int fails   = 0;

  run_controller #(.RESET_CYCLES(RC), .DEBOUNCE_CYCLES(DC), .COUNT_WIDTH(32)) u_dut (
    .CLK(clk), .RST_bar(RST_bar), .HALT(HALT), .RUN_REQ(RUN_REQ), .STEP_REQ(STEP_REQ),
    .RESET_REQ(RESET_REQ), .CPU_CLK_EN(en), .CPU_RST_bar(rstb), .RUNNING(running),
    .HALTED(halted), .CYCLE_COUNT(cnt)
  );

  run_controller #(.RESET_CYCLES(RC), .DEBOUNCE_CYCLES(DC), .COUNT_WIDTH(4)) u_dut4 (
    .CLK(clk), .RST_bar(RST_bar), .HALT(HALT), .RUN_REQ(RUN_REQ), .STEP_REQ(STEP_REQ),
    .RESET_REQ(RESET_REQ), .CPU_CLK_EN(en4), .CPU_RST_bar(rstb4), .RUNNING(running4),
    .HALTED(halted4), .CYCLE_COUNT(cnt4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural model: mode flags plus a remaining-reset-cycles count.
  int          m_rst_left = 0;
  bit          m_running = 0, m_stepping = 0, m_halted = 0, m_valid = 0;
  bit          m_level = 0, m_rose = 0, m_pulse = 0;
  logic [31:0] m_cnt = 0;
  logic [3:0]  m_cnt4 = 0;
  bit [1:0]    m_run_sh = 0, m_step_sh = 0;
  bit [2:0]    m_rreq_sh = 0;
  bit          m_hist[$];

  always @(posedge clk) begin : model
    bit rp, en_now, all_diff, new_level, run_sync;
    rp       = m_rreq_sh[1] && !m_rreq_sh[2];
    run_sync = m_run_sh[1];
    en_now   = (m_rst_left > 0) || ((m_running || m_stepping) && !HALT);
    if (!RST_bar) m_valid = 1;
    if (!RST_bar || rp) begin
      m_rst_left = RC;
      m_running  = 0;
      m_stepping = 0;
      m_halted   = 0;
      m_cnt      = 0;
      m_cnt4     = 0;
    end else begin
      if (en_now && m_rst_left == 0) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1;
      end
      if (m_rst_left > 0) m_rst_left = m_rst_left - 1;
      else if (m_halted) m_halted = 1;
      else if (m_running) begin
        if (HALT) begin m_running = 0; m_halted = 1; end
        else if (!run_sync) m_running = 0;
      end else if (m_stepping) begin
        m_stepping = 0;
        if (HALT) m_halted = 1;
      end else if (run_sync) m_running = 1;
      else if (m_pulse) m_stepping = 1;
    end
    if (!RST_bar) begin
      m_run_sh = 0; m_step_sh = 0; m_rreq_sh = 0;
      m_hist.delete();
      m_level = 0; m_rose = 0; m_pulse = 0;
    end else begin
      // Level flips once the last DC synchronised samples all disagree with it.
      m_hist.push_back(m_step_sh[1]);
      if (m_hist.size() > DC) void'(m_hist.pop_front());
      all_diff = (m_hist.size() == DC);
      foreach (m_hist[j]) if (m_hist[j] == m_level) all_diff = 0;
      new_level = all_diff ? !m_level : m_level;
      m_pulse   = m_rose;
      m_rose    = new_level && !m_level;
      m_level   = new_level;
      m_run_sh  = {m_run_sh[0], RUN_REQ};
      m_step_sh = {m_step_sh[0], STEP_REQ};
      m_rreq_sh = {m_rreq_sh[1:0], RESET_REQ};
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      bit e;
      e = (m_rst_left > 0) || ((m_running || m_stepping) && !HALT);
      chk("cpu_rst_bar", rstb, m_rst_left == 0);
      chk("cpu_clk_en", en, e);
      chk("running", running, m_running);
      chk("halted", halted, m_halted);
      chk("cycle_count", cnt, m_cnt);
      chk("cycle_count_w4", cnt4, m_cnt4);
      chk("cpu_clk_en_w4", en4, e);
    end
  end

  initial begin
    int lows, lat, seen, base, guard;
    RST_bar = 0; HALT = 0; RUN_REQ = 0; STEP_REQ = 0; RESET_REQ = 0;

    // Reset: two low cycles, then exactly RC reset cycles after release.
    cyc(2);
    RST_bar = 1;
    chk("rst_val_rst_bar", rstb, 0);
    chk("rst_val_clk_en", en, 1);
    chk("rst_val_running", running, 0);
    chk("rst_val_halted", halted, 0);
    chk("rst_val_count", cnt, 0);
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      if (!rstb) lows++;
      cyc(1);
    end
    chk("rst_len", lows, RC);
    chk("idle_clk_en", en, 0);
    chk("idle_count", cnt, 0);

    // Free-run for 100 cycles.
    RUN_REQ = 1; lat = -1;
    for (int i = 1; i <= 100; i++) begin
      cyc(1);
      if (running && lat < 0) lat = i;
    end
    chk("run_latency", lat, 3);
    RUN_REQ = 0;
    cyc(6);
    chk("run_count", cnt, 100);
    chk("run_back_idle", running, 0);
    chk("sat_w4", cnt4, 15);

    // Clean step: latency and a single enable.
    base = cnt; STEP_REQ = 1; lat = -1; seen = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (en) begin seen++; if (lat < 0) lat = i; end
    end
    chk("step_latency", lat, DC + 4);
    STEP_REQ = 0;
    for (int i = 0; i < 25; i++) begin cyc(1); if (en) seen++; end
    chk("step_one_en", seen, 1);
    chk("step_count", cnt - base, 1);

    // Bouncing button, then held high: one step only.
    base = cnt; seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) STEP_REQ = ~STEP_REQ;
      cyc(1);
      if (en) seen++;
    end
    STEP_REQ = 1;
    for (int i = 0; i < 40; i++) begin cyc(1); if (en) seen++; end
    STEP_REQ = 0;
    for (int i = 0; i < 25; i++) begin cyc(1); if (en) seen++; end
    chk("bounce_one_en", seen, 1);
    chk("bounce_count", cnt - base, 1);

    // Halt at count 57.
    RST_bar = 0; cyc(1); RST_bar = 1; cyc(RC + 2);
    RUN_REQ = 1; guard = 0;
    while (cnt != 57 && guard < 400) begin cyc(1); guard++; end
    chk("halt_reach57", guard < 400, 1);
    HALT = 1; #1;
    chk("halt_en_same_cycle", en, 0);
    cyc(1);
    chk("halted_next", halted, 1);
    chk("halt_count_hold", cnt, 57);
    STEP_REQ = 1; cyc(30); STEP_REQ = 0; cyc(25);
    chk("halt_sticky", halted, 1);
    chk("halt_count_final", cnt, 57);

    // Recover with RESET_REQ.
    RUN_REQ = 0; HALT = 0; RESET_REQ = 1; lat = -1;
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      if (!rstb && lat < 0) begin lat = i; chk("recover_count_zero", cnt, 0); end
    end
    RESET_REQ = 0;
    chk("recover_latency", lat, 3);
    cyc(8);
    chk("recover_idle_rst_bar", rstb, 1);
    chk("recover_idle_halted", halted, 0);
    chk("recover_idle_en", en, 0);

    // RUN and step pulse land in the same IDLE cycle.
    STEP_REQ = 1; cyc(DC + 1); RUN_REQ = 1; seen = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (en && rstb && !running) seen++;
    end
    chk("race_no_step", seen, 0);
    chk("race_running", running, 1);
    RUN_REQ = 0; STEP_REQ = 0; cyc(25);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) RUN_REQ = ~RUN_REQ;
      if ($urandom_range(0, 29) == 0) STEP_REQ = ~STEP_REQ;
      HALT = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 149) == 0) RESET_REQ = ~RESET_REQ;
      RST_bar = ($urandom_range(0, 699) != 0);
      cyc(1);
    end
    RST_bar = 1; HALT = 0;
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
